mem_port_arbiter: RTL and testbench

Two-to-one arbiter/sequencer placed between the fetch-stage instruction sram-like port and the execute-stage data sram-like port on one side, and the single shared sram-like port toward the AXI bridge on the other. It selects one requester per cycle and holds that grant stable until the address handshake completes. It tracks outstanding transactions in an in-order ID FIFO and routes each data_ok/rdata back to the requester that issued it.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-to-one sram-like port arbiter: data-first (or round-robin with ARB_RR_EN), grant held until addr_ok,
// in-order ID FIFO routes data_ok/rdata back to the issuing requester.
module mem_port_arbiter #(
  parameter int OUTST_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [31:0]      inst_addr,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic             m_req,
  output logic             m_wr,
  output logic [1:0]       m_size,
  output logic [31:0]      m_addr,
  output logic [3:0]       m_wstrb,
  output logic [31:0]      m_wdata,
  input  logic             m_addr_ok,
  input  logic             m_data_ok,
  input  logic [31:0]      m_rdata,
  output logic [PTR_W:0]   outst_cnt,
  output logic             resp_err
);

  logic [PTR_W:0]       cnt_q, cnt_d;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [OUTST_DEPTH-1:0] id_q;
  logic                 lock_q, lock_id_q;
  logic                 resp_err_q;
  logic                 gnt_vld, gnt_id;
  logic                 full, empty, push, pop, head_id;

`ifdef ARB_RR_EN
  logic                 prio_q;
`endif

  assign full  = (cnt_q == (PTR_W+1)'(OUTST_DEPTH));
  assign empty = (cnt_q == '0);

  // ID 1 = data side, ID 0 = inst side
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (lock_q) begin
      gnt_id  = lock_id_q;
      gnt_vld = lock_id_q ? data_req : inst_req;
    end else begin
`ifdef ARB_RR_EN
      if (data_req && inst_req) begin
        gnt_vld = 1'b1;
        gnt_id  = prio_q;
      end else if (data_req) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end else if (inst_req) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
`else
      if (data_req) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end else if (inst_req) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end
`endif
    end
  end

  assign m_req   = gnt_vld && !full;
  assign m_wr    = gnt_vld ? (gnt_id ? data_wr    : inst_wr)    : 1'b0;
  assign m_size  = gnt_vld ? (gnt_id ? data_size  : inst_size)  : 2'b0;
  assign m_addr  = gnt_vld ? (gnt_id ? data_addr  : inst_addr)  : 32'h0;
  assign m_wstrb = gnt_vld ? (gnt_id ? data_wstrb : inst_wstrb) : 4'h0;
  assign m_wdata = gnt_vld ? (gnt_id ? data_wdata : inst_wdata) : 32'h0;

  assign push = m_req && m_addr_ok;
  assign pop  = m_data_ok && !empty;

  assign inst_addr_ok = push && !gnt_id;
  assign data_addr_ok = push && gnt_id;

  assign head_id      = id_q[rd_ptr_q];
  assign inst_data_ok = pop && !head_id;
  assign data_data_ok = pop && head_id;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  assign outst_cnt = cnt_q;
  assign resp_err  = resp_err_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      id_q       <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= 1'b0;
      resp_err_q <= 1'b0;
`ifdef ARB_RR_EN
      prio_q     <= 1'b1;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        id_q[wr_ptr_q] <= gnt_id;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
`ifdef ARB_RR_EN
        prio_q         <= ~prio_q;
`endif
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (m_data_ok && empty)
        resp_err_q <= 1'b1;
      // Hold the offered side until the downstream port takes it
      if (push) begin
        lock_q <= 1'b0;
      end else if (m_req) begin
        lock_q    <= 1'b1;
        lock_id_q <= gnt_id;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic inst_req, inst_wr, data_req, data_wr, m_addr_ok, m_data_ok;
  logic [1:0] inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, m_rdata;
  logic [3:0] inst_wstrb, data_wstrb;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic m_req, m_wr;
  logic [1:0] m_size;
  logic [31:0] m_addr, m_wdata;
  logic [3:0] m_wstrb;
  logic [2:0] outst_cnt;
  logic resp_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.OUTST_DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb),
    .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .outst_cnt(outst_cnt), .resp_err(resp_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: which side owns each outstanding transaction, in issue order
  int  pend_q[$];
  bit  committed;      // a side was offered to the port and not yet taken
  bit  committed_side; // 1 = data, 0 = inst
  bit  err;
  bit  prio = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    bit want, side, full, acc, ret;
    int head;
    want = 1'b0;
    side = 1'b0;
    full = (pend_q.size() == DEPTH);
    if (committed) begin
      side = committed_side;
      want = side ? data_req : inst_req;
    end else if (data_req && inst_req) begin
      want = 1'b1;
`ifdef ARB_RR_EN
      side = prio;
`else
      side = 1'b1;
`endif
    end else if (data_req || inst_req) begin
      want = 1'b1;
      side = data_req;
    end
    acc  = want && !full && m_addr_ok;
    ret  = m_data_ok && (pend_q.size() > 0);
    head = ret ? pend_q[0] : 0;

    chk("m_req", m_req, want && !full);
    chk("m_addr", m_addr, !want ? 0 : (side ? data_addr : inst_addr));
    chk("m_wdata", m_wdata, !want ? 0 : (side ? data_wdata : inst_wdata));
    chk("m_wr", m_wr, !want ? 0 : (side ? data_wr : inst_wr));
    chk("m_size", m_size, !want ? 0 : (side ? data_size : inst_size));
    chk("m_wstrb", m_wstrb, !want ? 0 : (side ? data_wstrb : inst_wstrb));
    chk("inst_addr_ok", inst_addr_ok, acc && !side);
    chk("data_addr_ok", data_addr_ok, acc && side);
    chk("inst_data_ok", inst_data_ok, ret && head == 0);
    chk("data_data_ok", data_data_ok, ret && head == 1);
    chk("inst_rdata", inst_rdata, m_rdata);
    chk("data_rdata", data_rdata, m_rdata);
    chk("outst_cnt", outst_cnt, pend_q.size());
    chk("resp_err", resp_err, err);

    if (reset) begin
      pend_q.delete();
      committed = 1'b0;
      err = 1'b0;
      prio = 1'b1;
    end else begin
      if (m_data_ok && pend_q.size() == 0) err = 1'b1;
      if (ret) void'(pend_q.pop_front());
      if (acc) begin
        pend_q.push_back(int'(side));
        committed = 1'b0;
        prio = ~prio;
      end else if (want && !full) begin
        committed = 1'b1;
        committed_side = side;
      end
    end
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * DEPTH && pend_q.size() > 0; i++) begin
      idle(); m_data_ok = 1; m_rdata = $urandom;
      sample(); adv();
    end
    chk("drain_done", pend_q.size(), 0);
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk("rst_outst_cnt", outst_cnt, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_m_req", m_req, 0);
    adv();
    reset = 0;

    // single inst read
    idle(); inst_req = 1; inst_addr = 32'h1C000000; m_addr_ok = 1;
    sample();
    chk("single_inst_addr_ok", inst_addr_ok, 1);
    chk("single_m_addr", m_addr, 32'h1C000000);
    adv();
    idle(); m_data_ok = 1; m_rdata = 32'h02800C0C;
    sample();
    chk("single_cnt1", outst_cnt, 1);
    chk("single_inst_data_ok", inst_data_ok, 1);
    chk("single_inst_rdata", inst_rdata, 32'h02800C0C);
    adv();
    idle();
    sample();
    chk("single_cnt0", outst_cnt, 0);
    adv();

    // contention: data wins, inst next cycle
    idle(); inst_req = 1; inst_addr = 32'h1C000004;
    data_req = 1; data_wr = 1; data_addr = 32'h1000; data_wstrb = 4'hF; data_wdata = 32'h12345678;
    m_addr_ok = 1;
    sample();
    chk("cont_data_addr_ok", data_addr_ok, 1);
    chk("cont_inst_addr_ok", inst_addr_ok, 0);
    chk("cont_m_wr", m_wr, 1);
    adv();
    data_req = 0;
    sample();
    chk("cont_inst_next", inst_addr_ok, 1);
    adv();
    drain();

    // lock: data rising during an unaccepted inst request is ignored
    idle(); inst_req = 1; inst_addr = 32'h1C000040; data_addr = 32'h2000;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) data_req = 1;
      sample();
      chk("lock_m_addr", m_addr, 32'h1C000040);
      chk("lock_data_addr_ok", data_addr_ok, 0);
      adv();
    end
    m_addr_ok = 1;
    sample();
    chk("lock_inst_addr_ok", inst_addr_ok, 1);
    adv();
    inst_req = 0;
    sample();
    chk("lock_data_next", data_addr_ok, 1);
    adv();
    drain();

    // full
    idle(); data_req = 1; data_addr = 32'h3000; m_addr_ok = 1;
    repeat (4) begin sample(); adv(); end
    sample();
    chk("full_cnt", outst_cnt, 4);
    chk("full_m_req", m_req, 0);
    adv();
    m_data_ok = 1; m_rdata = 32'h55;
    sample();
    chk("full_pop_m_req", m_req, 0);
    chk("full_pop_data_ok", data_data_ok, 1);
    adv();
    sample();
    chk("full_after_m_req", m_req, 1);
    chk("full_after_cnt", outst_cnt, 3);
    adv();
    idle();
    sample();
    chk("full_pushpop_cnt", outst_cnt, 3);
    adv();
    drain();

    // ordering with push+pop at count 2
    idle(); m_addr_ok = 1;
    inst_req = 1; sample(); adv();
    inst_req = 0; data_req = 1; sample(); adv();
    data_req = 0; inst_req = 1; sample(); adv();
    idle(); m_data_ok = 1; m_rdata = 32'hA;
    sample();
    chk("ord_a_inst", inst_data_ok, 1);
    chk("ord_a_rdata", inst_rdata, 32'hA);
    adv();
    m_rdata = 32'hB; inst_req = 1; m_addr_ok = 1;
    sample();
    chk("ord_b_cnt", outst_cnt, 2);
    chk("ord_b_data", data_data_ok, 1);
    chk("ord_b_rdata", data_rdata, 32'hB);
    adv();
    idle(); m_data_ok = 1; m_rdata = 32'hC;
    sample();
    chk("ord_pushpop_cnt", outst_cnt, 2);
    chk("ord_c_inst", inst_data_ok, 1);
    adv();
    drain();

    // error on empty response
    idle(); m_data_ok = 1;
    sample();
    chk("err_no_inst_ok", inst_data_ok, 0);
    chk("err_no_data_ok", data_data_ok, 0);
    adv();
    idle();
    sample();
    chk("err_sticky", resp_err, 1);
    adv();

    // reset mid-operation with 3 outstanding and a pending lock
    idle(); inst_req = 1; m_addr_ok = 1;
    repeat (3) begin sample(); adv(); end
    m_addr_ok = 0; inst_addr = 32'h1C000100;
    sample(); adv();
    idle(); reset = 1;
    sample(); adv();
    reset = 0;
    inst_req = 1; inst_addr = 32'h1C000200; data_req = 1; data_addr = 32'h4000;
    sample();
    chk("rst_mid_cnt", outst_cnt, 0);
    chk("rst_mid_err", resp_err, 0);
    chk("rst_mid_unlocked", m_addr, 32'h4000);
    adv();

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      inst_req   = $urandom_range(0, 1);
      inst_wr    = $urandom_range(0, 1);
      inst_size  = 2'($urandom_range(0, 2));
      inst_addr  = $urandom;
      inst_wstrb = 4'($urandom);
      inst_wdata = $urandom;
      data_req   = $urandom_range(0, 1);
      data_wr    = $urandom_range(0, 1);
      data_size  = 2'($urandom_range(0, 2));
      data_addr  = $urandom;
      data_wstrb = 4'($urandom);
      data_wdata = $urandom;
      m_addr_ok  = $urandom_range(0, 1);
      m_data_ok  = ($urandom_range(0, 2) == 0);
      m_rdata    = $urandom;
      sample();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
